// File: rtl/jump_interrupt_controller_if.sv
// Pipeline-side bundle for the jump/interrupt controller.
// The master is the pipeline (fetch/execute); the slave is the controller.
interface jump_interrupt_controller_if #(
  parameter int ADDR_W  = 16,
  parameter int NUM_IRQ = 4
) ();

  // Instruction and flag inputs coming from the pipeline
  logic [5:0]         op;
  logic [1:0]         flag_ex;
  logic [ADDR_W-1:0]  current_address;
  logic [ADDR_W-1:0]  jmp_address_pm;

  // Interrupt request side
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               int_en;

  // Controller results
  logic [ADDR_W-1:0]  jmp_loc;
  logic               pc_mux_sel;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               in_service;
  logic [1:0]         flag_restore;
  logic               flag_restore_valid;
  logic               stack_full;
  logic               ret_underflow;

  modport master (
    output op, flag_ex, current_address, jmp_address_pm,
           irq, irq_mask, int_en,
    input  jmp_loc, pc_mux_sel, irq_ack, in_service,
           flag_restore, flag_restore_valid, stack_full, ret_underflow
  );

  modport slave (
    input  op, flag_ex, current_address, jmp_address_pm,
           irq, irq_mask, int_en,
    output jmp_loc, pc_mux_sel, irq_ack, in_service,
           flag_restore, flag_restore_valid, stack_full, ret_underflow
  );

endinterface

// File: rtl/jump_interrupt_controller.sv
// Jump/branch controller with prioritised, nested, vectored interrupts.
// Branches and RET resolve combinationally in RUN. An accepted interrupt
// spends one ENTRY cycle steering the PC to its vector while the current
// address, flags and priority are pushed onto a small return stack.
module jump_interrupt_controller #(
  parameter int                ADDR_W      = 16,
  parameter int                NUM_IRQ     = 4,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE    = ADDR_W'(16'hF000),
  parameter logic [ADDR_W-1:0] VEC_STRIDE  = ADDR_W'(16'h0010)
) (
  input logic                        clk,
  input logic                        reset,
  jump_interrupt_controller_if.slave bus
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = PTR_W + 1;

  localparam logic [5:0] OP_JV  = 6'b011100;
  localparam logic [5:0] OP_JNV = 6'b011101;
  localparam logic [5:0] OP_JZ  = 6'b011110;
  localparam logic [5:0] OP_JNZ = 6'b011111;
  localparam logic [5:0] OP_JMP = 6'b011000;
  localparam logic [5:0] OP_RET = 6'b010000;

  typedef enum logic {
    RUN   = 1'b0,
    ENTRY = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SP_W-1:0]    sp_q, sp_d;
  logic [IDX_W-1:0]   win_q, win_d;

  logic [ADDR_W-1:0]  stack_addr_q [STACK_DEPTH];
  logic [ADDR_W-1:0]  stack_addr_d [STACK_DEPTH];
  logic [1:0]         stack_flag_q [STACK_DEPTH];
  logic [1:0]         stack_flag_d [STACK_DEPTH];
  logic [IDX_W-1:0]   stack_prio_q [STACK_DEPTH];
  logic [IDX_W-1:0]   stack_prio_d [STACK_DEPTH];

  logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;
  logic [1:0]         flag_restore_q, flag_restore_d;
  logic               flag_restore_valid_q, flag_restore_valid_d;
  logic               ret_underflow_q, ret_underflow_d;

  logic               is_jump;
  logic               is_ret;
  logic               is_ctrl;
  logic               taken;
  logic               flag_z;
  logic               flag_v;

  logic [NUM_IRQ-1:0] pend;
  logic [IDX_W-1:0]   pend_win;
  logic               accept;

  logic               stack_empty;
  logic               stack_is_full;
  logic [PTR_W-1:0]   top_idx;
  logic [PTR_W-1:0]   push_idx;

  logic [ADDR_W-1:0]  win_ext;
  logic [ADDR_W-1:0]  vec_addr;

  logic               pc_sel;
  logic [ADDR_W-1:0]  loc;

  assign flag_z = bus.flag_ex[1];
  assign flag_v = bus.flag_ex[0];

  assign stack_empty   = (sp_q == '0);
  assign stack_is_full = (sp_q == SP_W'(STACK_DEPTH));
  assign top_idx       = sp_q[PTR_W-1:0] - PTR_W'(1);
  assign push_idx      = sp_q[PTR_W-1:0];

  // Vector address of the latched winner, wrapping at the address width
  assign win_ext  = ADDR_W'(win_q);
  assign vec_addr = VEC_BASE + win_ext * VEC_STRIDE;

  // Opcode decode and branch condition using the live execute flags
  always_comb begin
    is_jump = 1'b0;
    is_ret  = 1'b0;
    taken   = 1'b0;
    unique case (bus.op)
      OP_JMP: begin
        is_jump = 1'b1;
        taken   = 1'b1;
      end
      OP_JV: begin
        is_jump = 1'b1;
        taken   = flag_v;
      end
      OP_JNV: begin
        is_jump = 1'b1;
        taken   = ~flag_v;
      end
      OP_JZ: begin
        is_jump = 1'b1;
        taken   = flag_z;
      end
      OP_JNZ: begin
        is_jump = 1'b1;
        taken   = ~flag_z;
      end
      OP_RET: begin
        is_ret = 1'b1;
      end
      default: begin
        is_jump = 1'b0;
      end
    endcase
    is_ctrl = is_jump | is_ret;
  end

  // Eligible requests and lowest-index winner among them
  always_comb begin
    pend     = bus.irq & ~bus.irq_mask & {NUM_IRQ{bus.int_en}};
    pend_win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        pend_win = IDX_W'(i);
      end
    end
  end

  // Acceptance needs a free stack slot and strict preemption of the top entry;
  // control ops own the cycle, so a pending interrupt simply waits for them
  always_comb begin
    accept = 1'b0;
    if ((state_q == RUN) && (pend != '0) && !is_ctrl && !stack_is_full) begin
      if (stack_empty || (pend_win < stack_prio_q[top_idx])) begin
        accept = 1'b1;
      end
    end
  end

  // Next-state, stack update and PC mux selection
  always_comb begin
    state_d              = state_q;
    sp_d                 = sp_q;
    win_d                = win_q;
    stack_addr_d         = stack_addr_q;
    stack_flag_d         = stack_flag_q;
    stack_prio_d         = stack_prio_q;
    irq_ack_d            = '0;
    flag_restore_d       = flag_restore_q;
    flag_restore_valid_d = 1'b0;
    ret_underflow_d      = 1'b0;
    pc_sel               = 1'b0;
    loc                  = '0;

    unique case (state_q)
      RUN: begin
        if (is_jump) begin
          if (taken) begin
            pc_sel = 1'b1;
            loc    = bus.jmp_address_pm;
          end
        end else if (is_ret) begin
          if (!stack_empty) begin
            pc_sel               = 1'b1;
            loc                  = stack_addr_q[top_idx];
            sp_d                 = sp_q - SP_W'(1);
            flag_restore_d       = stack_flag_q[top_idx];
            flag_restore_valid_d = 1'b1;
          end else begin
            ret_underflow_d = 1'b1;
          end
        end else if (accept) begin
          win_d   = pend_win;
          state_d = ENTRY;
        end
      end

      ENTRY: begin
        pc_sel                 = 1'b1;
        loc                    = vec_addr;
        stack_addr_d[push_idx] = bus.current_address;
        stack_flag_d[push_idx] = bus.flag_ex;
        stack_prio_d[push_idx] = win_q;
        sp_d                   = sp_q + SP_W'(1);
        irq_ack_d              = NUM_IRQ'(1) << win_q;
        state_d                = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, stack and registered outputs; reset also aborts a pending entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q              <= RUN;
      sp_q                 <= '0;
      win_q                <= '0;
      irq_ack_q            <= '0;
      flag_restore_q       <= '0;
      flag_restore_valid_q <= 1'b0;
      ret_underflow_q      <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_addr_q[i] <= '0;
        stack_flag_q[i] <= '0;
        stack_prio_q[i] <= '0;
      end
    end else begin
      state_q              <= state_d;
      sp_q                 <= sp_d;
      win_q                <= win_d;
      irq_ack_q            <= irq_ack_d;
      flag_restore_q       <= flag_restore_d;
      flag_restore_valid_q <= flag_restore_valid_d;
      ret_underflow_q      <= ret_underflow_d;
      stack_addr_q         <= stack_addr_d;
      stack_flag_q         <= stack_flag_d;
      stack_prio_q         <= stack_prio_d;
    end
  end

  assign bus.pc_mux_sel         = reset ? 1'b0 : pc_sel;
  assign bus.jmp_loc            = reset ? '0 : loc;
  assign bus.in_service         = reset ? 1'b0 : !stack_empty;
  assign bus.stack_full         = reset ? 1'b0 : stack_is_full;
  assign bus.irq_ack            = irq_ack_q;
  assign bus.flag_restore       = flag_restore_q;
  assign bus.flag_restore_valid = flag_restore_valid_q;
  assign bus.ret_underflow      = ret_underflow_q;

endmodule

// File: tb/tb_jump_interrupt_controller.sv
// Directed bench for jump_interrupt_controller: a branch-decode vector table
// followed by hand-written interrupt entry, nesting and RET sequences.
module tb_jump_interrupt_controller;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_JV  = 6'b011100;
  localparam logic [5:0] OP_JNV = 6'b011101;
  localparam logic [5:0] OP_JZ  = 6'b011110;
  localparam logic [5:0] OP_JNZ = 6'b011111;
  localparam logic [5:0] OP_JMP = 6'b011000;
  localparam logic [5:0] OP_RET = 6'b010000;

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  flags;
    logic [15:0] pm;
    logic        exp_sel;
    logic [15:0] exp_loc;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs [12];

  jump_interrupt_controller_if #(.ADDR_W(16), .NUM_IRQ(4)) bus ();

  jump_interrupt_controller #(
    .ADDR_W      (16),
    .NUM_IRQ     (4),
    .STACK_DEPTH (4),
    .VEC_BASE    (16'hF000),
    .VEC_STRIDE  (16'h0010)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [1:0] flags,
                               input logic [15:0] addr, input logic [15:0] pm,
                               input logic [3:0] irq);
    bus.op              = op;
    bus.flag_ex         = flags;
    bus.current_address = addr;
    bus.jmp_address_pm  = pm;
    bus.irq             = irq;
    #2;
  endtask

  // Accept in RUN, check the ENTRY vector, then check the acknowledge
  task automatic enterIrq(input logic [3:0] lines, input logic [15:0] addr,
                          input logic [1:0] flags, input logic [15:0] exp_vec,
                          input logic [3:0] exp_ack);
    applyStimulus(OP_NOP, flags, addr, 16'h0000, lines);
    checkOutput("accept_cycle_sel", 32'(bus.pc_mux_sel), 32'd0);
    stepClock();
    checkOutput("entry_sel", 32'(bus.pc_mux_sel), 32'd1);
    checkOutput("entry_vec", 32'(bus.jmp_loc), 32'(exp_vec));
    bus.irq = 4'b0000;
    stepClock();
    checkOutput("irq_ack", 32'(bus.irq_ack), 32'(exp_ack));
    checkOutput("in_service", 32'(bus.in_service), 32'd1);
  endtask

  // RET with a non-empty stack: address now, flags on the next cycle
  task automatic doRet(input logic [15:0] exp_addr, input logic [1:0] exp_flags);
    bus.op = OP_RET;
    #2;
    checkOutput("ret_sel", 32'(bus.pc_mux_sel), 32'd1);
    checkOutput("ret_addr", 32'(bus.jmp_loc), 32'(exp_addr));
    stepClock();
    bus.op = OP_NOP;
    checkOutput("ret_flag_valid", 32'(bus.flag_restore_valid), 32'd1);
    checkOutput("ret_flags", 32'(bus.flag_restore), 32'(exp_flags));
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{OP_JZ,  2'b10, 16'h0040, 1'b1, 16'h0040};
    vecs[1]  = '{OP_JZ,  2'b00, 16'h0040, 1'b0, 16'h0000};
    vecs[2]  = '{OP_JNZ, 2'b00, 16'h1234, 1'b1, 16'h1234};
    vecs[3]  = '{OP_JNZ, 2'b10, 16'h1234, 1'b0, 16'h0000};
    vecs[4]  = '{OP_JV,  2'b01, 16'hABCD, 1'b1, 16'hABCD};
    vecs[5]  = '{OP_JV,  2'b10, 16'hABCD, 1'b0, 16'h0000};
    vecs[6]  = '{OP_JNV, 2'b00, 16'h0F0F, 1'b1, 16'h0F0F};
    vecs[7]  = '{OP_JNV, 2'b11, 16'h0F0F, 1'b0, 16'h0000};
    vecs[8]  = '{OP_JMP, 2'b00, 16'hFFFE, 1'b1, 16'hFFFE};
    vecs[9]  = '{OP_JMP, 2'b11, 16'h0001, 1'b1, 16'h0001};
    vecs[10] = '{OP_NOP, 2'b11, 16'h5555, 1'b0, 16'h0000};
    vecs[11] = '{6'b011010, 2'b11, 16'h5555, 1'b0, 16'h0000};

    // Reset with a JMP present: combinational outputs forced low
    reset        = 1'b1;
    bus.irq_mask = 4'b0000;
    bus.int_en   = 1'b1;
    applyStimulus(OP_JMP, 2'b00, 16'h0000, 16'h1111, 4'b0000);
    checkOutput("reset_sel", 32'(bus.pc_mux_sel), 32'd0);
    checkOutput("reset_loc", 32'(bus.jmp_loc), 32'd0);
    stepClock();
    stepClock();
    checkOutput("reset_ack", 32'(bus.irq_ack), 32'd0);
    checkOutput("reset_frv", 32'(bus.flag_restore_valid), 32'd0);
    checkOutput("reset_uf", 32'(bus.ret_underflow), 32'd0);
    checkOutput("reset_in_service", 32'(bus.in_service), 32'd0);
    checkOutput("reset_full", 32'(bus.stack_full), 32'd0);
    reset = 1'b0;

    // Branch decode table
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].flags, 16'h0100, vecs[i].pm, 4'b0000);
      checkOutput($sformatf("vec%0d_sel", i), 32'(bus.pc_mux_sel), 32'(vecs[i].exp_sel));
      if (vecs[i].exp_sel) begin
        checkOutput($sformatf("vec%0d_loc", i), 32'(bus.jmp_loc), 32'(vecs[i].exp_loc));
      end
      stepClock();
    end

    // Single interrupt on line 2, request dropped during ENTRY, then RET
    enterIrq(4'b0100, 16'h0123, 2'b11, 16'hF020, 4'b0100);
    checkOutput("single_full", 32'(bus.stack_full), 32'd0);
    stepClock();
    checkOutput("ack_one_cycle", 32'(bus.irq_ack), 32'd0);
    bus.current_address = 16'h0200;
    bus.flag_ex         = 2'b00;
    doRet(16'h0123, 2'b11);
    checkOutput("after_ret_idle", 32'(bus.in_service), 32'd0);
    stepClock();
    checkOutput("frv_one_cycle", 32'(bus.flag_restore_valid), 32'd0);

    // Masked and globally disabled requests are ignored
    bus.int_en = 1'b0;
    applyStimulus(OP_NOP, 2'b00, 16'h0210, 16'h0000, 4'b0001);
    stepClock();
    checkOutput("int_en_off", 32'(bus.pc_mux_sel), 32'd0);
    bus.int_en   = 1'b1;
    bus.irq_mask = 4'b0001;
    stepClock();
    checkOutput("masked_line", 32'(bus.pc_mux_sel), 32'd0);
    enterIrq(4'b0011, 16'h0220, 2'b01, 16'hF010, 4'b0010);
    bus.irq_mask = 4'b0000;
    doRet(16'h0220, 2'b01);

    // Preemption: irq1 over irq2
    enterIrq(4'b0100, 16'h0300, 2'b01, 16'hF020, 4'b0100);
    enterIrq(4'b0110, 16'h0310, 2'b10, 16'hF010, 4'b0010);
    doRet(16'h0310, 2'b10);
    doRet(16'h0300, 2'b01);

    // Lower priority irq3 waits until the stack empties
    enterIrq(4'b0100, 16'h0400, 2'b00, 16'hF020, 4'b0100);
    applyStimulus(OP_NOP, 2'b00, 16'h0400, 16'h0000, 4'b1000);
    stepClock();
    checkOutput("no_preempt_sel", 32'(bus.pc_mux_sel), 32'd0);
    stepClock();
    checkOutput("no_preempt_ack", 32'(bus.irq_ack), 32'd0);
    doRet(16'h0400, 2'b00);
    stepClock();
    checkOutput("irq3_entry_sel", 32'(bus.pc_mux_sel), 32'd1);
    checkOutput("irq3_entry_vec", 32'(bus.jmp_loc), 32'hF030);
    bus.irq = 4'b0000;
    stepClock();
    checkOutput("irq3_ack", 32'(bus.irq_ack), 32'b1000);
    doRet(16'h0400, 2'b00);

    // Four nested levels fill the stack; a fifth request is blocked
    enterIrq(4'b1000, 16'h0A00, 2'b00, 16'hF030, 4'b1000);
    enterIrq(4'b0100, 16'h0A10, 2'b01, 16'hF020, 4'b0100);
    enterIrq(4'b0010, 16'h0A20, 2'b10, 16'hF010, 4'b0010);
    checkOutput("depth3_full", 32'(bus.stack_full), 32'd0);
    enterIrq(4'b0001, 16'h0A30, 2'b11, 16'hF000, 4'b0001);
    checkOutput("depth4_full", 32'(bus.stack_full), 32'd1);
    applyStimulus(OP_NOP, 2'b00, 16'h0B00, 16'h0000, 4'b0001);
    stepClock();
    checkOutput("fifth_blocked_sel", 32'(bus.pc_mux_sel), 32'd0);
    stepClock();
    checkOutput("fifth_blocked_ack", 32'(bus.irq_ack), 32'd0);
    bus.irq = 4'b0000;
    doRet(16'h0A30, 2'b11);
    checkOutput("pop_clears_full", 32'(bus.stack_full), 32'd0);
    doRet(16'h0A20, 2'b10);
    doRet(16'h0A10, 2'b01);
    doRet(16'h0A00, 2'b00);
    checkOutput("nest_unwound", 32'(bus.in_service), 32'd0);

    // RET with an empty stack
    applyStimulus(OP_RET, 2'b00, 16'h0C00, 16'h0000, 4'b0000);
    checkOutput("underflow_sel", 32'(bus.pc_mux_sel), 32'd0);
    stepClock();
    bus.op = OP_NOP;
    checkOutput("underflow_pulse", 32'(bus.ret_underflow), 32'd1);
    checkOutput("underflow_frv", 32'(bus.flag_restore_valid), 32'd0);
    checkOutput("underflow_sp", 32'(bus.in_service), 32'd0);
    stepClock();
    checkOutput("underflow_one_cycle", 32'(bus.ret_underflow), 32'd0);

    // JMP wins the cycle; entry follows one cycle later
    applyStimulus(OP_JMP, 2'b00, 16'h0D00, 16'h0777, 4'b0001);
    checkOutput("jmp_vs_irq_sel", 32'(bus.pc_mux_sel), 32'd1);
    checkOutput("jmp_vs_irq_loc", 32'(bus.jmp_loc), 32'h0777);
    stepClock();
    bus.op = OP_NOP;
    bus.current_address = 16'h0800;
    #2;
    checkOutput("deferred_accept_sel", 32'(bus.pc_mux_sel), 32'd0);
    stepClock();
    checkOutput("deferred_entry_vec", 32'(bus.jmp_loc), 32'hF000);
    bus.irq = 4'b0000;
    stepClock();
    checkOutput("deferred_ack", 32'(bus.irq_ack), 32'b0001);
    doRet(16'h0800, 2'b00);

    // Reset during ENTRY aborts the push and the acknowledge
    enterIrqAbort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic enterIrqAbort();
    applyStimulus(OP_NOP, 2'b10, 16'h0E00, 16'h0000, 4'b0010);
    stepClock();
    checkOutput("abort_entry_vec", 32'(bus.jmp_loc), 32'hF010);
    reset = 1'b1;
    #1;
    checkOutput("abort_reset_sel", 32'(bus.pc_mux_sel), 32'd0);
    checkOutput("abort_reset_loc", 32'(bus.jmp_loc), 32'd0);
    stepClock();
    bus.irq = 4'b0000;
    checkOutput("abort_ack", 32'(bus.irq_ack), 32'd0);
    checkOutput("abort_flag_restore", 32'(bus.flag_restore), 32'd0);
    reset = 1'b0;
    stepClock();
    checkOutput("abort_no_push", 32'(bus.in_service), 32'd0);
    checkOutput("abort_ack_late", 32'(bus.irq_ack), 32'd0);
    bus.op = OP_RET;
    stepClock();
    bus.op = OP_NOP;
    checkOutput("abort_empty_stack", 32'(bus.ret_underflow), 32'd1);
  endtask

endmodule
